// File: rtl/entrada_handshake.sv
// Device side of the processor IN path: synchronises and debounces the push-button,
// then hands one switch word per press to the I/O unit through a stall/valid handshake.
module entrada_handshake #(
  parameter int DATA_W       = 4,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_MAX = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              botao_in,
  input  logic [DATA_W-1:0] chaves_in,
  input  logic              req,
  output logic              stall,
  output logic              valid,
  output logic [31:0]       dados_out,
  output logic              espera
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    DONE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

  state_t            state_r;
  state_t            next_state_s;
  logic              botao_meta_r;
  logic              botao_sync_r;
  logic [DATA_W-1:0] chaves_meta_r;
  logic [DATA_W-1:0] chaves_sync_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              debounced_r;
  logic              debounced_prev_r;
  logic              press_s;
  logic              capture_s;
  logic              stall_s;

  // two-flop synchronisers for the button and every switch bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      botao_meta_r  <= 1'b0;
      botao_sync_r  <= 1'b0;
      chaves_meta_r <= '0;
      chaves_sync_r <= '0;
    end else begin
      botao_meta_r  <= botao_in;
      botao_sync_r  <= botao_meta_r;
      chaves_meta_r <= chaves_in;
      chaves_sync_r <= chaves_meta_r;
    end
  end

  // debounce: the new level must persist DEBOUNCE_MAX consecutive cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r            <= '0;
      debounced_r      <= 1'b0;
      debounced_prev_r <= 1'b0;
    end else begin
      debounced_prev_r <= debounced_r;
      if (botao_sync_r == debounced_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r       <= '0;
        debounced_r <= ~debounced_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign press_s = debounced_r & ~debounced_prev_r;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state and stall decode
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        stall_s = req;
        if (req) begin
          next_state_s = WAIT_PRESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_PRESS: begin
        stall_s = 1'b1;
        if (!req) begin
          next_state_s = IDLE;
        end else if (press_s) begin
          next_state_s = DONE;
          capture_s    = 1'b1;
        end else begin
          next_state_s = WAIT_PRESS;
        end
      end
      DONE: begin
        stall_s = 1'b0;
        if (debounced_r) begin
          next_state_s = WAIT_RELEASE;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_RELEASE: begin
        // a held button must be released before another IN can be served
        stall_s = req;
        if (!debounced_r) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_RELEASE;
        end
      end
      default: begin
        stall_s      = 1'b0;
        next_state_s = IDLE;
      end
    endcase
  end

  assign stall = stall_s & ~reset;

  // registered handshake outputs and captured word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= 1'b0;
      espera    <= 1'b0;
      dados_out <= 32'd0;
    end else begin
      valid  <= capture_s;
      espera <= (next_state_s == WAIT_PRESS);
      if (capture_s) begin
        dados_out <= {{(32-DATA_W){1'b0}}, chaves_sync_r};
      end else begin
        dados_out <= dados_out;
      end
    end
  end

endmodule

// File: tb/tb_entrada_handshake.sv
// Self-checking bench for entrada_handshake: directed scenarios plus random button/req
// traffic, compared every cycle against a behavioural model of the press/IN handshake.
module tb_entrada_handshake;

  localparam int DBM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        botao_in = 1'b0;
  logic [3:0]  chaves_in = 4'h0;
  logic        req = 1'b0;
  logic        stall;
  logic        valid;
  logic [31:0] dados_out;
  logic        espera;

  int total = 0;
  int bad = 0;
  int valid_seen = 0;

  // model: raw-input delay line, run length of disagreement, and IN bookkeeping flags
  bit          m_b1, m_b2, m_deb, m_deb_prev;
  logic [3:0]  m_c1, m_c2;
  int          run;
  bit          waiting, just_done, need_release;
  logic [31:0] m_data;

  entrada_handshake #(.DATA_W(4), .CNT_W(16), .DEBOUNCE_MAX(DBM)) dut (
    .clk(clk), .reset(reset), .botao_in(botao_in), .chaves_in(chaves_in),
    .req(req), .stall(stall), .valid(valid), .dados_out(dados_out), .espera(espera)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_b1 = 1'b0; m_b2 = 1'b0; m_deb = 1'b0; m_deb_prev = 1'b0;
    m_c1 = 4'h0; m_c2 = 4'h0; run = 0;
    waiting = 1'b0; just_done = 1'b0; need_release = 1'b0;
    m_data = 32'd0;
  endtask

  task automatic model_update();
    bit         old_sync, old_deb, pressed;
    logic [3:0] old_chv;
    old_sync = m_b2;
    old_deb  = m_deb;
    pressed  = m_deb && !m_deb_prev;
    old_chv  = m_c2;
    m_b2 = m_b1; m_b1 = botao_in;
    m_c2 = m_c1; m_c1 = chaves_in;
    if (old_sync != old_deb) begin
      run++;
      if (run == DBM) begin
        m_deb = !old_deb;
        run = 0;
      end
    end else begin
      run = 0;
    end
    m_deb_prev = old_deb;
    if (waiting) begin
      if (!req) waiting = 1'b0;
      else if (pressed) begin
        waiting = 1'b0; just_done = 1'b1; m_data = {28'd0, old_chv};
      end
    end else if (just_done) begin
      just_done = 1'b0; need_release = old_deb;
    end else if (need_release) begin
      if (!old_deb) need_release = 1'b0;
    end else if (req) begin
      waiting = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("stall", {31'd0, stall}, {31'd0, !reset && (waiting || (!just_done && req))});
    chk("valid", {31'd0, valid}, {31'd0, just_done});
    chk("espera", {31'd0, espera}, {31'd0, waiting});
    chk("dados_out", dados_out, m_data);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    #1;
    if (valid) valid_seen++;
    check_all();
  endtask

  initial begin
    int idx;
    int v0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_espera", {31'd0, espera}, 32'd0);
    chk("reset_dados", dados_out, 32'd0);
    step(); step();
    reset = 1'b0;

    // 1: basic IN with latency check
    chaves_in = 4'hA; req = 1'b1; botao_in = 1'b1;
    #1;
    chk("t1_stall_req", {31'd0, stall}, 32'd1);
    idx = 0;
    for (int i = 1; i <= 20 && idx == 0; i++) begin
      step();
      if (valid) idx = i;
    end
    chk("t1_latency", idx, 32'd7);
    chk("t1_stall_done", {31'd0, stall}, 32'd0);
    chk("t1_dados", dados_out, 32'h0000000A);
    req = 1'b0;
    repeat (12) step();
    botao_in = 1'b0;
    repeat (12) step();

    // 2: bounce rejection
    req = 1'b1; v0 = valid_seen;
    for (int i = 0; i < 6; i++) begin
      botao_in = (i % 2 == 0);
      step(); step();
    end
    chk("t2_no_early_valid", valid_seen - v0, 32'd0);
    botao_in = 1'b1;
    repeat (20) step();
    chk("t2_valid_count", valid_seen - v0, 32'd1);
    req = 1'b0; botao_in = 1'b0;
    repeat (12) step();

    // 3: presses while idle are not buffered
    reset = 1'b1; step(); reset = 1'b0; step();
    botao_in = 1'b1; repeat (12) step();
    botao_in = 1'b0; repeat (12) step();
    chaves_in = 4'h5; req = 1'b1; v0 = valid_seen;
    repeat (10) step();
    chk("t3_no_valid", valid_seen - v0, 32'd0);
    chk("t3_dados_hold", dados_out, 32'd0);
    botao_in = 1'b1; repeat (12) step();
    chk("t3_dados", dados_out, 32'h00000005);
    chk("t3_valid_count", valid_seen - v0, 32'd1);
    req = 1'b0; botao_in = 1'b0; repeat (12) step();

    // 4: one press per IN
    chaves_in = 4'h3; req = 1'b1; botao_in = 1'b1;
    repeat (12) step();
    chk("t4_first", dados_out, 32'h00000003);
    req = 1'b0; step(); step();
    chaves_in = 4'hC; req = 1'b1; v0 = valid_seen;
    repeat (15) step();
    chk("t4_held_no_valid", valid_seen - v0, 32'd0);
    chk("t4_held_stall", {31'd0, stall}, 32'd1);
    botao_in = 1'b0; repeat (10) step();
    botao_in = 1'b1; repeat (12) step();
    chk("t4_second", dados_out, 32'h0000000C);
    chk("t4_valid_count", valid_seen - v0, 32'd1);
    req = 1'b0; botao_in = 1'b0; repeat (12) step();

    // 5: abort before any press
    v0 = valid_seen; req = 1'b1;
    repeat (5) step();
    req = 1'b0; step();
    chk("t5_stall", {31'd0, stall}, 32'd0);
    chk("t5_espera", {31'd0, espera}, 32'd0);
    chk("t5_dados", dados_out, 32'h0000000C);
    chk("t5_no_valid", valid_seen - v0, 32'd0);

    // 6: asynchronous reset between edges
    chaves_in = 4'h9; req = 1'b1;
    repeat (3) step();
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_espera", {31'd0, espera}, 32'd0);
    chk("t6_valid", {31'd0, valid}, 32'd0);
    chk("t6_dados", dados_out, 32'd0);
    step();
    reset = 1'b0; v0 = valid_seen;
    step();
    botao_in = 1'b1; repeat (12) step();
    chk("t6_after", dados_out, 32'h00000009);
    chk("t6_valid_count", valid_seen - v0, 32'd1);
    req = 1'b0; botao_in = 1'b0; repeat (12) step();

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      req = ($urandom_range(0, 3) != 0);
      botao_in = 1'($urandom_range(0, 1));
      chaves_in = 4'($urandom);
      repeat ($urandom_range(1, 12)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
